dlm_bank_arb: RTL and testbench
===============================

// Module: dlm_bank_arb
// PURPOSE
//  Per-bank arbiter for the banked DLM SRAMs. Shares the DLM_NBANKS banks between two requesters:
//  - port 0: core load/store (LSU)
//  - port 1: DMC SRIF, driven by the slave-AXI side
//  Word-interleaved bank select. Fixed core priority per bank, with a starvation guard for DMC.
//  Registers the 1-cycle SRAM read return back to the originating port.
// PARAMETERS
//  NBANKS     2     number of DLM banks (power of 2, >=2); = P.DLM_NBANKS
//  BANK_AW    10    bank word-address width; = P.DLM_BANK_AW
//  DW         64    bank/port data width; = P.DLM_BANK_W
//  STARVE_MAX 4     consecutive DMC losses on one bank before DMC is forced to win (1..15)
//  derived: NBE=DW/8, BSW=$clog2(NBANKS), OFFW=$clog2(NBE), AW=BANK_AW+BSW+OFFW
// PORTS
//  clk             in   1            clock; all state on rising edge
//  rst             in   1            synchronous active-high reset
//  core_req_valid  in   1            core request valid
//  core_req_ready  out  1            core request accepted this cycle
//  core_req_we     in   1            1=write, 0=read
//  core_req_addr   in   AW           byte address, DLM-relative
//  core_req_wdata  in   DW           write data
//  core_req_be     in   NBE          byte enables (writes)
//  core_rsp_valid  out  1            read data valid
//  core_rsp_rdata  out  DW           read data
//  dmc_req_*/dmc_rsp_*  same set as core_*, for the DMC port
//  bank_ce         out  NBANKS       per-bank chip enable
//  bank_we         out  NBANKS       per-bank write enable
//  bank_addr       out  NBANKS*BANK_AW   per-bank word address
//  bank_wdata      out  NBANKS*DW    per-bank write data
//  bank_be         out  NBANKS*NBE   per-bank byte enables
//  bank_rdata      in   NBANKS*DW    per-bank read data, valid 1 cycle after ce&!we
//  conflict_cnt    out  32           only with DLM_BANK_ARB_STATS_EN
// BEHAVIOUR
//  - Address split: bank = addr[OFFW +: BSW]; word = addr[OFFW+BSW +: BANK_AW]; addr[OFFW-1:0] ignored.
//  - Grant is combinational, decided per bank b.
//    - Only one port targets b: that port wins.
//    - Both target b: core wins unless starve_cnt[b]==STARVE_MAX, in which case DMC wins.
//    - Different banks: both ports are granted in the same cycle.
//  - req_ready = req_valid & granted. ready must never be asserted while valid is low.
//    A request transfers on valid&ready. The requester holds valid and payload until ready.
//  - bank_ce[b] = a grant exists on b. bank_we/addr/wdata/be come from the winner.
//    With no grant, all bank_* fields of b are driven 0.
//  - starve_cnt[b] (4b, per bank):
//    - +1 when both ports request b and core wins.
//    - Cleared to 0 when DMC is granted b.
//    - Otherwise holds. Never exceeds STARVE_MAX.
//  - Read latency is exactly 1 cycle.
//    - An accepted read sets rd_pend_q[port] and captures bank_sel_q[port].
//    - Next cycle: rsp_valid=1 and rsp_rdata = bank_rdata[bank_sel_q].
//    - rsp_valid is 1-cycle wide; the port has no rsp backpressure.
//    - Back-to-back reads give back-to-back rsp_valid.
//  - Writes produce no response; completion = acceptance.
//  - rsp_rdata is 0 whenever rsp_valid=0.
//  - Reset values: all req_ready=0, rsp_valid=0, rsp_rdata=0, bank_ce=0, bank_we=0;
//    starve_cnt=0, rd_pend_q=0, bank_sel_q=0.
//  - Reset mid-operation: a read accepted in the cycle rst is sampled gets no response.
//    Outputs are forced to reset values while rst=1, regardless of req_valid.
//  - Same-address write (core) + read (DMC) on one bank: only the winner is serviced.
//    The loser retries and sees the post-write data.
// CONFIGURATION
//  - `define DLM_BANK_ARB_STATS_EN: adds output conflict_cnt[31:0].
//    - +1 per cycle in which any bank has both ports requesting it; saturates at 32'hFFFF_FFFF.
//    - Reset to 0.
//  - Without the macro: the port and counter are absent. Arbitration behaviour is identical.
// TESTING
//  1 - Input: core read addr 0x08 (bank1, word0), DMC idle.
//    - Expect: core_ready=1 and bank_ce=2'b10.
//    - Expect: core_rsp_valid=1 next cycle with bank1 rdata.
//  2 - Input: core write 0x00 + DMC read 0x08 in the same cycle.
//    - Expect: both ready=1, bank_ce=2'b11, bank_we=2'b01.
//    - Expect: dmc_rsp_valid=1 next cycle.
//  3 - Input: core and DMC both hold requests to 0x10 (bank0) continuously.
//    - Expect: core wins 4 cycles, DMC wins the 5th; pattern repeats.
//    - Expect: starve_cnt 0,1,2,3,4,0.
//  4 - Input: rst=1 for one cycle right after a core read is accepted.
//    - Expect: core_rsp_valid stays 0; all outputs at reset values during rst.
//  5 - Input: 8 back-to-back core reads 0x00..0x38.
//    - Expect: 8 consecutive rsp_valid cycles, data in order, alternating bank_ce 01/10.
//  6 - Input: with DLM_BANK_ARB_STATS_EN, 3 conflict cycles plus 2 non-conflict cycles.
//    - Expect: conflict_cnt=3.

Source files
------------

// File: rtl/dlm_bank_arb_if.sv
// rtl/dlm_bank_arb_if.sv - signal bundle between dlm_bank_arb and its requesters/banks
// Purpose: groups the core and DMC request/response ports and the per-bank SRAM ports.
// Ports (modports):
//   slave  - arbiter side: takes core_req_*/dmc_req_*, drives *_req_ready, *_rsp_*, bank_*,
//            receives bank_rdata
//   master - environment side: requesters and SRAM banks (mirror of slave)
// Bank vectors are flat, bank b occupying slice [b*W +: W].
interface dlm_bank_arb_if #(
  parameter int NBANKS  = 2,
  parameter int BANK_AW = 10,
  parameter int DW      = 64
);
  localparam int NBE  = DW / 8;
  localparam int BSW  = $clog2(NBANKS);
  localparam int OFFW = $clog2(NBE);
  localparam int AW   = BANK_AW + BSW + OFFW;

  logic                      core_req_valid;
  logic                      core_req_ready;
  logic                      core_req_we;
  logic [AW-1:0]             core_req_addr;
  logic [DW-1:0]             core_req_wdata;
  logic [NBE-1:0]            core_req_be;
  logic                      core_rsp_valid;
  logic [DW-1:0]             core_rsp_rdata;

  logic                      dmc_req_valid;
  logic                      dmc_req_ready;
  logic                      dmc_req_we;
  logic [AW-1:0]             dmc_req_addr;
  logic [DW-1:0]             dmc_req_wdata;
  logic [NBE-1:0]            dmc_req_be;
  logic                      dmc_rsp_valid;
  logic [DW-1:0]             dmc_rsp_rdata;

  logic [NBANKS-1:0]         bank_ce;
  logic [NBANKS-1:0]         bank_we;
  logic [NBANKS*BANK_AW-1:0] bank_addr;
  logic [NBANKS*DW-1:0]      bank_wdata;
  logic [NBANKS*NBE-1:0]     bank_be;
  logic [NBANKS*DW-1:0]      bank_rdata;

  modport slave (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_be,
    output core_req_ready, core_rsp_valid, core_rsp_rdata,
    input  dmc_req_valid, dmc_req_we, dmc_req_addr, dmc_req_wdata, dmc_req_be,
    output dmc_req_ready, dmc_rsp_valid, dmc_rsp_rdata,
    output bank_ce, bank_we, bank_addr, bank_wdata, bank_be,
    input  bank_rdata
  );

  modport master (
    output core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_be,
    input  core_req_ready, core_rsp_valid, core_rsp_rdata,
    output dmc_req_valid, dmc_req_we, dmc_req_addr, dmc_req_wdata, dmc_req_be,
    input  dmc_req_ready, dmc_rsp_valid, dmc_rsp_rdata,
    input  bank_ce, bank_we, bank_addr, bank_wdata, bank_be,
    output bank_rdata
  );
endinterface

// File: rtl/dlm_bank_arb.sv
// rtl/dlm_bank_arb.sv - per-bank core/DMC arbiter for the banked DLM SRAMs
// Purpose: shares NBANKS word-interleaved SRAM banks between the core LSU (port 0) and the
//   DMC SRIF (port 1). Core has fixed priority on a contested bank; after STARVE_MAX
//   consecutive DMC losses on that bank DMC is forced to win. Reads return 1 cycle later.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          dlm_bank_arb_if.slave: core/dmc req+rsp, bank_* SRAM ports
//   conflict_cnt saturating count of cycles with a contested bank (DLM_BANK_ARB_STATS_EN only)
// Optional feature macro: DLM_BANK_ARB_STATS_EN
module dlm_bank_arb #(
  parameter int NBANKS     = 2,
  parameter int BANK_AW    = 10,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  dlm_bank_arb_if.slave bus
`ifdef DLM_BANK_ARB_STATS_EN
  ,
  output logic [31:0]   conflict_cnt
`endif
);
  localparam int NBE  = DW / 8;
  localparam int BSW  = $clog2(NBANKS);
  localparam int OFFW = $clog2(NBE);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [BSW-1:0]                 core_bank, dmc_bank;
  logic [BANK_AW-1:0]             core_word, dmc_word;
  logic [2*OFFW-1:0]              unused_offset;
  logic [NBANKS-1:0]              core_tgt, dmc_tgt, both_req, core_gnt, dmc_gnt;
  logic                           core_ready, dmc_ready;
  logic [NBANKS-1:0][3:0]         starve_cnt_d, starve_cnt_q;
  logic [1:0]                     rd_pend_d, rd_pend_q;
  logic [1:0][BSW-1:0]            bank_sel_d, bank_sel_q;
  logic [NBANKS-1:0]              ce_b, we_b;
  logic [NBANKS-1:0][BANK_AW-1:0] addr_b;
  logic [NBANKS-1:0][DW-1:0]      wdata_b, rdata_b;
  logic [NBANKS-1:0][NBE-1:0]     be_b;
  logic                           core_rsp_valid, dmc_rsp_valid;

  // Word interleave: bank select sits just above the byte offset, which is dropped.
  assign core_bank     = bus.core_req_addr[OFFW +: BSW];
  assign core_word     = bus.core_req_addr[OFFW+BSW +: BANK_AW];
  assign dmc_bank      = bus.dmc_req_addr[OFFW +: BSW];
  assign dmc_word      = bus.dmc_req_addr[OFFW+BSW +: BANK_AW];
  assign unused_offset = {bus.core_req_addr[OFFW-1:0], bus.dmc_req_addr[OFFW-1:0]};

  always_comb begin
    core_tgt = '0;
    dmc_tgt  = '0;
    both_req = '0;
    core_gnt = '0;
    dmc_gnt  = '0;
    for (int b = 0; b < NBANKS; b++) begin
      core_tgt[b] = bus.core_req_valid && (core_bank == BSW'(b));
      dmc_tgt[b]  = bus.dmc_req_valid && (dmc_bank == BSW'(b));
      both_req[b] = core_tgt[b] && dmc_tgt[b];
      // On a contested bank DMC wins only once its loss streak has reached STARVE_MAX.
      core_gnt[b] = !rst && core_tgt[b] && !(both_req[b] && starve_cnt_q[b] == SMAX);
      dmc_gnt[b]  = !rst && dmc_tgt[b] && !(both_req[b] && starve_cnt_q[b] != SMAX);
    end
  end

  assign core_ready = |core_gnt;
  assign dmc_ready  = |dmc_gnt;

  always_comb begin
    ce_b    = '0;
    we_b    = '0;
    addr_b  = '0;
    wdata_b = '0;
    be_b    = '0;
    for (int b = 0; b < NBANKS; b++) begin
      ce_b[b] = core_gnt[b] || dmc_gnt[b];
      if (core_gnt[b]) begin
        we_b[b]    = bus.core_req_we;
        addr_b[b]  = core_word;
        wdata_b[b] = bus.core_req_wdata;
        be_b[b]    = bus.core_req_be;
      end else if (dmc_gnt[b]) begin
        we_b[b]    = bus.dmc_req_we;
        addr_b[b]  = dmc_word;
        wdata_b[b] = bus.dmc_req_wdata;
        be_b[b]    = bus.dmc_req_be;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    for (int b = 0; b < NBANKS; b++) begin
      if (dmc_gnt[b]) begin
        starve_cnt_d[b] = '0;
      end else if (both_req[b] && core_gnt[b]) begin
        starve_cnt_d[b] = starve_cnt_q[b] + 4'd1;
      end
    end
    rd_pend_d  = {dmc_ready && !bus.dmc_req_we, core_ready && !bus.core_req_we};
    bank_sel_d = bank_sel_q;
    if (rd_pend_d[0]) bank_sel_d[0] = core_bank;
    if (rd_pend_d[1]) bank_sel_d[1] = dmc_bank;
  end

`ifdef DLM_BANK_ARB_STATS_EN
  logic [31:0] conflict_cnt_d, conflict_cnt_q;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((|both_req) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_cnt_q <= '0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= '0;
      bank_sel_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      bank_sel_q   <= bank_sel_d;
    end
  end

  // Responses are masked by rst so a read accepted just before reset never returns.
  assign core_rsp_valid = rd_pend_q[0] && !rst;
  assign dmc_rsp_valid  = rd_pend_q[1] && !rst;
  assign rdata_b        = bus.bank_rdata;

  assign bus.core_req_ready = core_ready;
  assign bus.dmc_req_ready  = dmc_ready;
  assign bus.core_rsp_valid = core_rsp_valid;
  assign bus.dmc_rsp_valid  = dmc_rsp_valid;
  assign bus.core_rsp_rdata = core_rsp_valid ? rdata_b[bank_sel_q[0]] : '0;
  assign bus.dmc_rsp_rdata  = dmc_rsp_valid ? rdata_b[bank_sel_q[1]] : '0;
  assign bus.bank_ce        = ce_b;
  assign bus.bank_we        = we_b;
  assign bus.bank_addr      = addr_b;
  assign bus.bank_wdata     = wdata_b;
  assign bus.bank_be        = be_b;
endmodule

// File: tb/tb_dlm_bank_arb.sv
// tb/tb_dlm_bank_arb.sv - self-checking bench for dlm_bank_arb with flat-memory reference model
module tb_dlm_bank_arb;
  localparam int NB = 2, BAW = 10, DW = 64, NBE = 8, AW = 14, SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  dlm_bank_arb_if #(.NBANKS(NB), .BANK_AW(BAW), .DW(DW)) bus ();
`ifdef DLM_BANK_ARB_STATS_EN
  logic [31:0] conflict_cnt;
`endif

  dlm_bank_arb #(.NBANKS(NB), .BANK_AW(BAW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DLM_BANK_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NBE-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NBE; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  // Banked SRAM environment: 1-cycle registered read.
  logic [DW-1:0]          sram [NB][1<<BAW];
  logic [NB-1:0][DW-1:0]  rdata_q = '0;
  assign bus.bank_rdata = rdata_q;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.bank_ce[b]) begin
        if (bus.bank_we[b])
          sram[b][bus.bank_addr[b*BAW +: BAW]] <= merge(sram[b][bus.bank_addr[b*BAW +: BAW]],
              bus.bank_wdata[b*DW +: DW], bus.bank_be[b*NBE +: NBE]);
        else
          rdata_q[b] <= sram[b][bus.bank_addr[b*BAW +: BAW]];
      end
    end
  end

  // Reference model: flat word memory plus per-bank DMC loss streaks.
  logic [DW-1:0]  ref_mem [2048];
  int             losses [NB];
  logic           c_v = 0, c_we = 0, d_v = 0, d_we = 0;
  logic [AW-1:0]  c_a = '0, d_a = '0;
  logic [DW-1:0]  c_wd = '0, d_wd = '0;
  logic [NBE-1:0] c_be = '0, d_be = '0;
  logic           cg = 0, dg = 0;
  logic [NB-1:0]  exp_ce, exp_we;
  logic           exp_crv = 0, exp_drv = 0;
  logic [DW-1:0]  exp_crd = '0, exp_drd = '0;

  task automatic set_core(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [NBE-1:0] be);
    c_v = v; c_we = we; c_a = a; c_wd = wd; c_be = be;
    bus.core_req_valid = v; bus.core_req_we = we; bus.core_req_addr = a;
    bus.core_req_wdata = wd; bus.core_req_be = be;
  endtask

  task automatic set_dmc(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [NBE-1:0] be);
    d_v = v; d_we = we; d_a = a; d_wd = wd; d_be = be;
    bus.dmc_req_valid = v; bus.dmc_req_we = we; bus.dmc_req_addr = a;
    bus.dmc_req_wdata = wd; bus.dmc_req_be = be;
  endtask

  function automatic int bank_of(input logic [AW-1:0] a);
    return int'(a[AW-1:3]) % NB;
  endfunction

  // Decide this cycle's grants from the arbitration rules; call once per cycle.
  task automatic eval();
    int cb, db;
    cb = bank_of(c_a);
    db = bank_of(d_a);
    cg = c_v;
    dg = d_v;
    if (c_v && d_v && cb == db) begin
      if (losses[cb] == SMAX) begin cg = 0; losses[cb] = 0; end
      else begin dg = 0; losses[cb] = losses[cb] + 1; end
    end else if (d_v) begin
      losses[db] = 0;
    end
    exp_ce = '0;
    exp_we = '0;
    if (cg) begin exp_ce[cb] = 1'b1; exp_we[cb] = c_we; end
    if (dg) begin exp_ce[db] = 1'b1; exp_we[db] = d_we; end
  endtask

  task automatic advance();
    logic nv_c, nv_d;
    logic [DW-1:0] nd_c, nd_d;
    nv_c = cg && !c_we;
    nv_d = dg && !d_we;
    nd_c = nv_c ? ref_mem[c_a[AW-1:3]] : '0;
    nd_d = nv_d ? ref_mem[d_a[AW-1:3]] : '0;
    if (cg && c_we) ref_mem[c_a[AW-1:3]] = merge(ref_mem[c_a[AW-1:3]], c_wd, c_be);
    if (dg && d_we) ref_mem[d_a[AW-1:3]] = merge(ref_mem[d_a[AW-1:3]], d_wd, d_be);
    @(posedge clk);
    #1;
    exp_crv = nv_c; exp_crd = nd_c;
    exp_drv = nv_d; exp_drd = nd_d;
  endtask

  task automatic do_reset();
    set_core(0, 0, '0, '0, '0);
    set_dmc(0, 0, '0, '0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int b = 0; b < NB; b++) losses[b] = 0;
    cg = 0; dg = 0; exp_crv = 0; exp_drv = 0; exp_crd = '0; exp_drd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_core(1, 0, 14'h08, '0, '0);
    set_dmc(1, 1, 14'h00, 64'hFFFF, 8'hFF);
    @(posedge clk); #1; @(posedge clk); #3;
    total++; if (bus.core_req_ready !== 1'b0) begin bad++; $display("FAIL rst_core_ready got=%0b want=0", bus.core_req_ready); end
    total++; if (bus.dmc_req_ready !== 1'b0) begin bad++; $display("FAIL rst_dmc_ready got=%0b want=0", bus.dmc_req_ready); end
    total++; if (bus.bank_ce !== 2'b00 || bus.bank_we !== 2'b00) begin bad++; $display("FAIL rst_bank got ce=%b we=%b want 00/00", bus.bank_ce, bus.bank_we); end
    total++; if (bus.core_rsp_valid !== 1'b0 || bus.dmc_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b%b want=00", bus.core_rsp_valid, bus.dmc_rsp_valid); end
    total++; if (bus.core_rsp_rdata !== '0 || bus.dmc_rsp_rdata !== '0) begin bad++; $display("FAIL rst_rsp_rdata got=%h/%h want=0", bus.core_rsp_rdata, bus.dmc_rsp_rdata); end
    total++; if (dut.starve_cnt_q !== '0) begin bad++; $display("FAIL rst_starve got=%h want=0", dut.starve_cnt_q); end
    do_reset();
  endtask

  task automatic preload();
    for (int w = 0; w < 16; w++) begin
      set_core(1, 1, AW'(w * 8), {$urandom, $urandom}, 8'hFF);
      eval();
      advance();
    end
    set_core(0, 0, '0, '0, '0);
  endtask

  task automatic test_single_read();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    set_core(1, 1, 14'h08, d, 8'hFF); eval(); advance();
    set_core(1, 0, 14'h08, '0, '0); eval(); #3;
    total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL t1_ready got=%0b want=1", bus.core_req_ready); end
    total++; if (bus.bank_ce !== 2'b10) begin bad++; $display("FAIL t1_ce got=%b want=10", bus.bank_ce); end
    advance();
    set_core(0, 0, '0, '0, '0); eval(); #3;
    total++; if (bus.core_rsp_valid !== 1'b1) begin bad++; $display("FAIL t1_rsp_valid got=%0b want=1", bus.core_rsp_valid); end
    total++; if (bus.core_rsp_rdata !== d) begin bad++; $display("FAIL t1_rdata got=%h want=%h", bus.core_rsp_rdata, d); end
    advance();
  endtask

  task automatic test_parallel();
    logic [DW-1:0] want;
    want = ref_mem[11'd1];
    set_core(1, 1, 14'h00, {$urandom, $urandom}, 8'h0F);
    set_dmc(1, 0, 14'h08, '0, '0);
    eval(); #3;
    total++; if (bus.core_req_ready !== 1'b1 || bus.dmc_req_ready !== 1'b1) begin bad++; $display("FAIL t2_ready got=%b%b want=11", bus.core_req_ready, bus.dmc_req_ready); end
    total++; if (bus.bank_ce !== 2'b11) begin bad++; $display("FAIL t2_ce got=%b want=11", bus.bank_ce); end
    total++; if (bus.bank_we !== 2'b01) begin bad++; $display("FAIL t2_we got=%b want=01", bus.bank_we); end
    advance();
    set_core(0, 0, '0, '0, '0); set_dmc(0, 0, '0, '0, '0); eval(); #3;
    total++; if (bus.dmc_rsp_valid !== 1'b1 || bus.core_rsp_valid !== 1'b0) begin bad++; $display("FAIL t2_rsp_valid got core=%0b dmc=%0b want core=0 dmc=1", bus.core_rsp_valid, bus.dmc_rsp_valid); end
    total++; if (bus.dmc_rsp_rdata !== want) begin bad++; $display("FAIL t2_rdata got=%h want=%h", bus.dmc_rsp_rdata, want); end
    advance();
  endtask

  task automatic test_starve();
    do_reset();
    set_core(1, 0, 14'h10, '0, '0);
    set_dmc(1, 0, 14'h10, '0, '0);
    for (int i = 0; i < 10; i++) begin
      eval(); #3;
      total++; if (bus.core_req_ready !== (i % 5 != 4)) begin bad++; $display("FAIL t3_core_ready cyc=%0d got=%0b want=%0b", i, bus.core_req_ready, (i % 5 != 4)); end
      total++; if (bus.dmc_req_ready !== (i % 5 == 4)) begin bad++; $display("FAIL t3_dmc_ready cyc=%0d got=%0b want=%0b", i, bus.dmc_req_ready, (i % 5 == 4)); end
      total++; if (dut.starve_cnt_q[0] !== 4'(i % 5)) begin bad++; $display("FAIL t3_starve cyc=%0d got=%0d want=%0d", i, dut.starve_cnt_q[0], i % 5); end
      total++; if (bus.bank_ce !== 2'b01) begin bad++; $display("FAIL t3_ce cyc=%0d got=%b want=01", i, bus.bank_ce); end
      total++; if (bus.core_rsp_valid !== exp_crv || bus.dmc_rsp_valid !== exp_drv) begin bad++; $display("FAIL t3_rsp cyc=%0d got=%b%b want=%b%b", i, bus.core_rsp_valid, bus.dmc_rsp_valid, exp_crv, exp_drv); end
      advance();
    end
    set_core(0, 0, '0, '0, '0); set_dmc(0, 0, '0, '0, '0); eval(); advance();
  endtask

  task automatic test_reset_mid();
    set_core(1, 0, 14'h18, '0, '0); eval(); #3;
    total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL t4_accept got=%0b want=1", bus.core_req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    set_dmc(1, 0, 14'h08, '0, '0);
    #3;
    total++; if (bus.core_rsp_valid !== 1'b0 || bus.core_rsp_rdata !== '0) begin bad++; $display("FAIL t4_rsp_in_rst got v=%0b d=%h want 0/0", bus.core_rsp_valid, bus.core_rsp_rdata); end
    total++; if (bus.core_req_ready !== 1'b0 || bus.dmc_req_ready !== 1'b0 || bus.bank_ce !== 2'b00) begin bad++; $display("FAIL t4_out_in_rst got rdy=%b%b ce=%b want 00/00", bus.core_req_ready, bus.dmc_req_ready, bus.bank_ce); end
    do_reset();
    eval(); #3;
    total++; if (bus.core_rsp_valid !== 1'b0) begin bad++; $display("FAIL t4_rsp_after_rst got=%0b want=0", bus.core_rsp_valid); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want;
    set_dmc(0, 0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_core(1, 0, AW'(i * 8), '0, '0);
      else       set_core(0, 0, '0, '0, '0);
      eval(); #3;
      if (i < 8) begin
        total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL t5_ready cyc=%0d got=%0b want=1", i, bus.core_req_ready); end
        total++; if (bus.bank_ce !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL t5_ce cyc=%0d got=%b", i, bus.bank_ce); end
      end
      want = (i >= 1 && i <= 8) ? ref_mem[11'(i - 1)] : '0;
      total++; if (bus.core_rsp_valid !== (i >= 1 && i <= 8)) begin bad++; $display("FAIL t5_rsp_valid cyc=%0d got=%0b", i, bus.core_rsp_valid); end
      total++; if (bus.core_rsp_rdata !== want) begin bad++; $display("FAIL t5_rdata cyc=%0d got=%h want=%h", i, bus.core_rsp_rdata, want); end
      advance();
    end
  endtask

  task automatic test_random();
    set_core(0, 0, '0, '0, '0);
    set_dmc(0, 0, '0, '0, '0);
    for (int n = 0; n < 400; n++) begin
      if (!(c_v && !cg))
        set_core($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                 {$urandom, $urandom}, NBE'($urandom));
      if (!(d_v && !dg))
        set_dmc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                {$urandom, $urandom}, NBE'($urandom));
      eval(); #3;
      total++; if (bus.core_req_ready !== cg || bus.dmc_req_ready !== dg) begin bad++; $display("FAIL rnd_ready n=%0d got=%b%b want=%b%b", n, bus.core_req_ready, bus.dmc_req_ready, cg, dg); end
      total++; if (bus.bank_ce !== exp_ce || bus.bank_we !== exp_we) begin bad++; $display("FAIL rnd_bank n=%0d got ce=%b we=%b want ce=%b we=%b", n, bus.bank_ce, bus.bank_we, exp_ce, exp_we); end
      total++; if (bus.core_rsp_valid !== exp_crv || bus.core_rsp_rdata !== exp_crd) begin bad++; $display("FAIL rnd_core_rsp n=%0d got=%0b/%h want=%0b/%h", n, bus.core_rsp_valid, bus.core_rsp_rdata, exp_crv, exp_crd); end
      total++; if (bus.dmc_rsp_valid !== exp_drv || bus.dmc_rsp_rdata !== exp_drd) begin bad++; $display("FAIL rnd_dmc_rsp n=%0d got=%0b/%h want=%0b/%h", n, bus.dmc_rsp_valid, bus.dmc_rsp_rdata, exp_drv, exp_drd); end
      advance();
    end
    set_core(0, 0, '0, '0, '0); set_dmc(0, 0, '0, '0, '0); eval(); advance();
  endtask

`ifdef DLM_BANK_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    #3;
    total++; if (conflict_cnt !== 32'd0) begin bad++; $display("FAIL t6_cnt_reset got=%0d want=0", conflict_cnt); end
    for (int i = 0; i < 5; i++) begin
      set_core(1, 0, 14'h00, '0, '0);
      set_dmc(1, 0, (i < 3) ? 14'h20 : 14'h08, '0, '0);
      eval(); advance();
    end
    set_core(0, 0, '0, '0, '0); set_dmc(0, 0, '0, '0, '0); eval(); #3;
    total++; if (conflict_cnt !== 32'd3) begin bad++; $display("FAIL t6_cnt got=%0d want=3", conflict_cnt); end
    advance();
  endtask
`endif

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_parallel();
    test_starve();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef DLM_BANK_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
